// File: rtl/rv_mc_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_mc_alu_pkg
// Brief    : Opcode and state encodings shared by the multi-cycle ALU slice.
// Revision : 1.0 - initial release
// ============================================================================
package rv_mc_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_MUL   = 4'd11,
    ALU_MULHU = 4'd12,
    ALU_DIVU  = 4'd13,
    ALU_REMU  = 4'd14
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

  function automatic logic is_mul(alu_op_e op);
    return (op == ALU_MUL) || (op == ALU_MULHU);
  endfunction

  function automatic logic is_div(alu_op_e op);
    return (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  // High product half and remainder both live in the upper accumulator half.
  function automatic logic sel_hi(alu_op_e op);
    return (op == ALU_MULHU) || (op == ALU_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_mc_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : rv_mc_alu_if
// Brief    : Request/response bundle between issue logic and rv_mc_alu.
//            Member names carry the ALU's own direction suffixes.
// Revision : 1.0 - initial release
// ============================================================================
interface rv_mc_alu_if #(
  parameter int WIDTH = 32
);
  logic                     flush_i;
  logic                     in_valid_i;
  logic                     in_ready_o;
  rv_mc_alu_pkg::alu_op_e   op_i;
  logic [WIDTH-1:0]         operand_a_i;
  logic [WIDTH-1:0]         operand_b_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [WIDTH-1:0]         result_o;
  logic                     zero_o;
  logic                     busy_o;

  modport master (
    output flush_i, in_valid_i, op_i, operand_a_i, operand_b_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, zero_o, busy_o
  );

  modport slave (
    input  flush_i, in_valid_i, op_i, operand_a_i, operand_b_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, zero_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/rv_mc_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : rv_mc_alu_muldiv
// Brief    : Shared iterative datapath: unsigned shift-add multiply and
//            restoring divide, one bit per cycle, WIDTH iterations.
//            o_result is combinational off the final step so the caller can
//            register it in the cycle o_done is high.
// Revision : 1.0 - initial release
// ============================================================================
module rv_mc_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_flush,
  input  wire logic             i_start,
  input  wire logic             i_is_div,
  input  wire logic             i_sel_hi,
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  output logic                  o_done,
  output logic [WIDTH-1:0]      o_result
);
  localparam int c_CNT_W = $clog2(WIDTH);

  logic               r_active;
  logic               r_is_div;
  logic               r_sel_hi;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_b;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;

  // One iteration: multiply adds B into the high half and shifts right;
  // divide shifts the remainder left and subtracts B when it fits.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_b};
    if (r_is_div) begin
      if (!w_diff[WIDTH]) begin
        w_hi_nxt = w_diff[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shift[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_sum[WIDTH:1];
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_done   = r_active && (r_cnt == '0);
  assign o_result = r_sel_hi ? w_hi_nxt : w_lo_nxt;

  // Operand load on start, then step and count down until the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_is_div <= 1'b0;
      r_sel_hi <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
    end else if (i_flush) begin
      r_active <= 1'b0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_is_div <= i_is_div;
      r_sel_hi <= i_sel_hi;
      r_cnt    <= c_CNT_W'(WIDTH - 1);
      r_hi     <= '0;
      r_lo     <= i_a;
      r_b      <= i_b;
    end else if (r_active) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv_mc_alu.sv
`default_nettype none
// ============================================================================
// Module   : rv_mc_alu
// Brief    : Multi-cycle ALU with valid/ready handshake and registered result.
//            Single-cycle logic/arith/shift ops; iterative MUL/MULHU/DIVU/REMU
//            only when RV_ALU_MULDIV_EN is defined (otherwise they return 0).
// Revision : 1.0 - initial release
// ============================================================================
module rv_mc_alu
  import rv_mc_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic   clk_i,
  input  wire logic   rst_ni,
  rv_mc_alu_if.slave  bus
);
  localparam int c_CNT_W = $clog2(WIDTH);

  alu_state_e         r_state;
  alu_state_e         w_state_nxt;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_load_sc;
  logic               w_load_md;
  logic [c_CNT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_sc_result;
  logic [WIDTH-1:0]   w_md_result;
  logic               w_md_done;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
`ifdef RV_ALU_MULDIV_EN
  logic               w_md_start;
`endif

  assign w_shamt    = bus.operand_b_i[c_CNT_W-1:0];
  // Reset and flush both hold off new requests.
  assign w_in_ready = rst_ni && !bus.flush_i &&
                      ((r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready_i));
  assign w_accept   = bus.in_valid_i && w_in_ready;

  // Single-cycle operation results; also covers divide-by-zero early exit.
  always_comb begin
    w_sc_result = '0;
    case (bus.op_i)
      ALU_ADD:  w_sc_result = bus.operand_a_i + bus.operand_b_i;
      ALU_SUB:  w_sc_result = bus.operand_a_i - bus.operand_b_i;
      ALU_AND:  w_sc_result = bus.operand_a_i & bus.operand_b_i;
      ALU_OR:   w_sc_result = bus.operand_a_i | bus.operand_b_i;
      ALU_XOR:  w_sc_result = bus.operand_a_i ^ bus.operand_b_i;
      ALU_NOR:  w_sc_result = ~(bus.operand_a_i | bus.operand_b_i);
      ALU_SLT:  w_sc_result = {{(WIDTH-1){1'b0}},
                               ($signed(bus.operand_a_i) < $signed(bus.operand_b_i))};
      ALU_SLTU: w_sc_result = {{(WIDTH-1){1'b0}}, (bus.operand_a_i < bus.operand_b_i)};
      ALU_SLL:  w_sc_result = bus.operand_a_i << w_shamt;
      ALU_SRL:  w_sc_result = bus.operand_a_i >> w_shamt;
      ALU_SRA:  w_sc_result = $unsigned($signed(bus.operand_a_i) >>> w_shamt);
`ifdef RV_ALU_MULDIV_EN
      ALU_DIVU: w_sc_result = '1;
      ALU_REMU: w_sc_result = bus.operand_a_i;
`endif
      default:  w_sc_result = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and load strobes; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_load_sc   = 1'b0;
    w_load_md   = 1'b0;
`ifdef RV_ALU_MULDIV_EN
    w_md_start  = 1'b0;
`endif
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if ((r_state == ST_DONE) && bus.out_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
        if (w_accept) begin
          w_state_nxt = ST_DONE;
          w_load_sc   = 1'b1;
`ifdef RV_ALU_MULDIV_EN
          if (is_mul(bus.op_i)) begin
            w_state_nxt = ST_MUL;
            w_load_sc   = 1'b0;
            w_md_start  = 1'b1;
          end else if (is_div(bus.op_i) && (bus.operand_b_i != '0)) begin
            w_state_nxt = ST_DIV;
            w_load_sc   = 1'b0;
            w_md_start  = 1'b1;
          end
`endif
        end
      end
`ifdef RV_ALU_MULDIV_EN
      ST_MUL, ST_DIV: begin
        if (w_md_done) begin
          w_state_nxt = ST_DONE;
          w_load_md   = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
    if (bus.flush_i) begin
      w_state_nxt = ST_IDLE;
      w_load_sc   = 1'b0;
      w_load_md   = 1'b0;
`ifdef RV_ALU_MULDIV_EN
      w_md_start  = 1'b0;
`endif
    end
  end

`ifdef RV_ALU_MULDIV_EN
  rv_mc_alu_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .i_flush  (bus.flush_i),
    .i_start  (w_md_start),
    .i_is_div (is_div(bus.op_i)),
    .i_sel_hi (sel_hi(bus.op_i)),
    .i_a      (bus.operand_a_i),
    .i_b      (bus.operand_b_i),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );
  assign bus.busy_o = (r_state == ST_MUL) || (r_state == ST_DIV);
`else
  assign w_md_done   = 1'b0;
  assign w_md_result = '0;
  assign bus.busy_o  = 1'b0;
`endif

  // Result register: captured on accept or at the end of iteration, then held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_load_sc) begin
      r_result <= w_sc_result;
      r_zero   <= (w_sc_result == '0);
    end else if (w_load_md && w_md_done) begin
      r_result <= w_md_result;
      r_zero   <= (w_md_result == '0);
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = (r_state == ST_DONE);
  assign bus.result_o    = r_result;
  assign bus.zero_o      = r_zero;

endmodule
`default_nettype wire

// File: doc/rv_mc_alu.md
Name: rv_mc_alu

Overview:
- Parametrised multi-cycle ALU; successor to the single-cycle combinational ALU in the execute stage.
- Adds signed/unsigned compare, XOR, shifts, and iterative unsigned multiply/divide behind a valid/ready handshake.
- Registered outputs; one operation in flight at a time.
- Sits between the decode/issue register and the writeback mux; stalls the pipe through `in_ready_o`.

Parameters:
- WIDTH, 32, operand/result width; power of two, 8..64.
- CNT_W, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous abort of any in-flight op
- in_valid_i  in  1  request valid
- in_ready_o  out  1  block can accept request
- op_i  in  alu_op_e (4)  operation select
- operand_a_i  in  WIDTH  operand A
- operand_b_i  in  WIDTH  operand B
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- result_o  out  WIDTH  registered result
- zero_o  out  1  registered, result_o == 0
- busy_o  out  1  iterative op in progress

Behaviour:
- Reset (async, `rst_ni` low):
  - state=IDLE.
  - `out_valid_o`=0, `result_o`=0, `zero_o`=0, `busy_o`=0, `in_ready_o`=0 while reset is asserted.
  - Reset mid-operation discards the op; no partial result is emitted.
- States: IDLE, MUL, DIV, DONE.
- Accept condition: `in_valid_i && in_ready_o`. `in_ready_o` = (state==IDLE) || (state==DONE && `out_ready_i`). This gives back-to-back issue.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA):
  - Latency 1; result registered on accept; next state DONE.
- Arithmetic and width rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is a signed compare; SLTU is unsigned. Both return 1/0 zero-extended.
  - Shift amount = `operand_b_i[CNT_W-1:0]`; upper bits ignored. SRA replicates the MSB.
- MUL / MULHU: unsigned shift-add, one bit per cycle.
  - WIDTH cycles in MUL, then DONE; latency WIDTH+1 from accept.
  - 2*WIDTH product. MUL returns the low half; MULHU returns the high half.
- DIVU / REMU: restoring division, one quotient bit per cycle, WIDTH cycles in DIV, latency WIDTH+1.
  - Divisor==0: skip iteration and go to DONE at latency 1. DIVU returns all-ones; REMU returns `operand_a_i`.
- Counter: loaded with WIDTH-1 on entry, decremented each cycle; leave the state at 0. `busy_o`=1 in MUL/DIV.
- DONE:
  - `out_valid_o`=1. `result_o`/`zero_o` hold stable until `out_ready_i`.
  - On handshake: go to IDLE, or load the new op if accepted the same cycle.
- flush_i: from any state, next state IDLE, `out_valid_o`=0. A request presented in the same cycle is NOT accepted (`in_ready_o` forced 0 while `flush_i`=1).
- Unsupported/undefined `op_i`: treated as single-cycle, result 0.

Optional Feature:
- Macro: RV_ALU_MULDIV_EN.
- Defined: MUL/MULHU/DIVU/REMU iterate as above.
- Not defined:
  - MUL and DIV states and the datapath are not elaborated.
  - Those four opcodes behave as single-cycle with result 0.
  - `busy_o` is tied 0.

Decomposition:
- rv_pkg additions:
  - `alu_op_e` 4-bit enum: ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, MUL, MULHU, DIVU, REMU.
  - `alu_state_e`.
- Sub-module rv_mc_alu_muldiv holds the shared shift-add/restoring-divide datapath and counter (start/done interface). The top module holds the FSM, handshake and single-cycle ops.

Test Plan:
- WIDTH=32: ADD 0xFFFFFFFF+1 -> `result_o`=0, `zero_o`=1, `out_valid_o` one cycle after accept.
- SLT 0xFFFFFFFF, 1 -> 1; SLTU same operands -> 0; SRA 0x80000000 by 0x21 -> 0xC0000000 (shamt 1).
- MUL 0x10000 x 0x10000 -> `result_o`=0; MULHU same -> 1; each `out_valid_o` exactly 33 cycles after accept, `busy_o` high 32 cycles.
- Divide cases:
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - DIVU 5/0 -> 0xFFFFFFFF at latency 1; REMU 5/0 -> 5.
- Backpressure: hold `out_ready_i`=0 for 5 cycles after ADD -> result stable, `in_ready_o`=0. Then raise `out_ready_i` with a new SUB valid -> SUB accepted that cycle, result next cycle.
- Abort cases:
  - Assert `flush_i` at cycle 10 of a DIVU -> no `out_valid_o`, IDLE next cycle.
  - Drop `rst_ni` mid-MUL -> all outputs 0 immediately (async).
  - Without RV_ALU_MULDIV_EN: MUL 3x4 -> 0 at latency 1.
